// File: rtl/vga_pkg.sv
// Shared constants and the packed pixel-word layout for the VGA plot path.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_MSB   = 15;
  localparam int X_LSB   = 8;
  localparam int Y_MSB   = 7;
  localparam int Y_LSB   = 1;
  localparam int COL_BIT = 0;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] WHITE  = 3'b111;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] BLUE   = 3'b001;

  typedef struct packed {
    logic [X_MSB-X_LSB:0] x;
    logic [Y_MSB-Y_LSB:0] y;
    logic                 colour;
  } pix_word_t;

endpackage

// File: rtl/vga_pixel_writer_if.sv
// Packed pixel-word valid/ready bus from the sprite/background mux.
interface vga_pixel_writer_if;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_word, output in_valid, input in_ready);
  modport slave  (input in_word, input in_valid, output in_ready);
endinterface

// File: rtl/pixel_fifo.sv
// DEPTH x W synchronous FIFO; pushes when full and pops when empty are ignored.
module pixel_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_pixel_writer.sv
// Buffers packed pixel words and plays them onto the vga_adapter plot port, one per clock.
module vga_pixel_writer
  import vga_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [2:0] FG_COLOUR = WHITE,
  parameter logic [2:0] BG_COLOUR = BLACK,
  parameter int         CNT_W     = 8
) (
  input  logic             clock,
  input  logic             resetn,
  vga_pixel_writer_if.slave pix,
  input  logic             stall,
  output logic [7:0]       vga_x,
  output logic [6:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  logic          full, empty, push, pop;
  logic [AW:0]   count;
  logic [15:0]   head;
  pix_word_t     word;
  logic          in_range;

  assign pix.in_ready = !full;
  assign push         = pix.in_valid && !full;
  assign pop          = !empty && !stall;
  assign word         = pix_word_t'(head);
  assign in_range     = (word.x < 8'(SCREEN_W)) && (word.y < 7'(SCREEN_H));
  assign busy         = (count != '0) || vga_plot;

  pixel_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .din    (pix.in_word),
    .pop    (pop),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  // Out-of-range words are still consumed so they never block the stream.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      drop_count <= '0;
    end else begin
      vga_plot <= 1'b0;
      if (pop) begin
        if (in_range) begin
          vga_x      <= word.x;
          vga_y      <= word.y;
          vga_colour <= word.colour ? FG_COLOUR : BG_COLOUR;
          vga_plot   <= 1'b1;
        end else if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/vga_pixel_writer.md
Name: vga_pixel_writer

Overview:
- Consumer end of the packed pixel-word bus driven by the sprite/background select mux.
- Accepts 16-bit words {x[7:0], y[6:0], colour} with a valid/ready handshake and buffers them in a small FIFO.
- Unpacks each word, range-checks it against the 160x120 frame, and drives the vga_adapter plot interface at one pixel per clock.
- Sits between the drawing FSMs/mux and vga_adapter.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- FG_COLOUR, 3'b111, 3-bit colour driven when the packed colour bit = 1.
- BG_COLOUR, 3'b000, 3-bit colour driven when the packed colour bit = 0.
- CNT_W, 8, width of drop_count.

Ports:
- clock  in  1  system clock (50 MHz); all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_word  in  16  packed pixel: [15:8]=x, [7:1]=y, [0]=colour.
- in_valid  in  1  in_word valid this cycle.
- in_ready  out  1  block can accept a word this cycle.
- stall  in  1  when high, no word is popped and vga_plot is forced low next cycle.
- vga_x  out  8  pixel x to vga_adapter.
- vga_y  out  7  pixel y to vga_adapter.
- vga_colour  out  3  pixel colour to vga_adapter.
- vga_plot  out  1  write enable to vga_adapter.
- drop_count  out  CNT_W  saturating count of out-of-range words discarded.
- busy  out  1  FIFO non-empty or vga_plot high.

Behaviour:
- Reset: resetn low clears the FIFO (pointers and count = 0) and sets vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, drop_count=0. This takes effect immediately, independent of clock. Any word in flight or buffered is discarded.
- Handshake:
  - in_ready = !full (combinational from the FIFO count, never from in_valid).
  - Push occurs on an edge where in_valid && in_ready; in_word is captured.
  - in_word need not be held after acceptance; the upstream may change it freely while in_valid is low.
- Pop: occurs on an edge where !empty && !stall. The head word is unpacked into registered outputs on that same edge.
  - Range check: x < 160 and y < 120.
  - In range: vga_x, vga_y updated; vga_colour = FG_COLOUR or BG_COLOUR per bit 0; vga_plot = 1 for exactly one cycle.
  - Out of range: word consumed, vga_x/y/colour hold, vga_plot = 0, drop_count += 1, saturating at 2^CNT_W-1.
- No pop on an edge: vga_plot = 0 and vga_x/y/colour hold their last values.
- Latency: a word accepted at edge k is popped no earlier than edge k+1, so vga_plot is high in the cycle after edge k+1 (minimum 2 edges). There is no input-to-output bypass.
- Throughput: one pixel per clock while stall is low and the FIFO is non-empty.
- Order: strictly FIFO; no reordering or merging.
- Simultaneous push and pop:
  - Not full and not empty: both occur; count unchanged.
  - Empty: push only (no bypass).
  - Full: in_ready is low, so no push, even if a pop occurs on the same edge; in_ready rises the following cycle.
- Wrap-around: read/write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits; full = (count == DEPTH).
- stall asserted mid-burst: the pop stops on that edge, vga_plot falls the next cycle, and the FIFO contents are preserved. Deasserting stall resumes with the next word in order.
- busy is combinational: (count != 0) || vga_plot.

Decomposition:
- Shared package vga_pkg holds:
  - SCREEN_W=160, SCREEN_H=120.
  - Packed-field constants X_MSB=15, X_LSB=8, Y_MSB=7, Y_LSB=1, COL_BIT=0.
  - Colour constants (BLACK, WHITE, YELLOW=3'b110, BLUE=3'b001).
  - The packed pixel-word typedef.
- Sub-module pixel_fifo: synchronous DEPTH x 16 FIFO with push, pop, dout, full, empty and count, and async active-low reset. vga_pixel_writer adds the unpack, range check, colour expansion and counter around it.

Test Plan:
- Reset/idle: hold resetn low, then release with in_valid=0 -> in_ready=1, vga_plot=0, busy=0, drop_count=0, and all vga_* outputs = 0.
- Single pixel: push 16'h3229 (x=50, y=20, colour=1) at edge k -> in the cycle after edge k+1: vga_plot=1 for one cycle, vga_x=50, vga_y=20, vga_colour=3'b111; then busy=0.
- Fill/full with stall=1: push 5 consecutive words -> in_ready drops after the 4th is accepted and the 5th is not taken. Release stall -> 4 plots on 4 consecutive cycles in push order; in_ready rises in the cycle after the first pop.
- Out-of-range: push x=160,y=0 then x=10,y=119 then x=0,y=120 -> one plot only (10,119); drop_count=2; the held vga_x/y remain (10,119).
- Streaming with stall toggling: continuous pushes with stall high every third cycle -> no lost, duplicated or reordered pixels. Compare against a scoreboard; the FIFO never overflows.
- Reset mid-operation: 3 words buffered, then pulse resetn low between edges -> outputs clear immediately; after release no buffered word is ever plotted, and drop_count=0.
